blocking: RTL and testbench
===========================

BLOCKING -- requirements
Module: blocking

Interface
REQ-001 Parameter WIDTH, default 8, data and output bit width.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rstn  input  1  reset, asynchronous and active-low.
REQ-004 data  input  WIDTH  sample value captured every rising clk edge.
REQ-005 q_a1_reg  output  WIDTH  stage-1 register.
REQ-006 q_a2_reg  output  WIDTH  stage-2 register, loaded from the updated stage-1 value.
REQ-007 q_a3_reg  output  WIDTH  stage-3 register, loaded from the updated stage-2 value.
REQ-008 All outputs SHALL be driven directly by flip-flops, with no combinational path from data to any output.

Function
REQ-009 On each rising clk edge with rstn=1, the chain SHALL update in order: stage 1 takes data, then stage 2 takes the new stage-1 value, then stage 3 takes the new stage-2 value.
REQ-010 Net effect per edge: q_a1_reg = q_a2_reg = q_a3_reg = data sampled at that edge.
REQ-011 Latency from data to each output SHALL be exactly 1 clk edge.
REQ-012 The three outputs SHALL always hold identical values, both out of reset and after any edge.
REQ-013 data changes between edges SHALL have no effect until the next rising edge.
REQ-014 No enable, handshake, arithmetic or wrap-around behaviour; every edge loads.

Reset
REQ-015 While rstn=0, q_a1_reg, q_a2_reg and q_a3_reg SHALL be all-zero, independent of clk.
REQ-016 Assertion of rstn SHALL clear the outputs immediately, including mid-stream with nonzero values held.
REQ-017 After rstn rises, the first rising edge SHALL load data normally.
REQ-018 An edge coinciding with rstn deassertion is not guaranteed to load; the bench SHALL drive rstn away from edges.

Configuration
REQ-019 Macro BLOCKING_PIPE_CMP_EN, when defined, SHALL add outputs q_b1_reg, q_b2_reg and q_b3_reg (each WIDTH) plus a 1-bit mismatch output.
REQ-020 With BLOCKING_PIPE_CMP_EN defined, q_b1..q_b3 SHALL form a true 3-stage shift chain: q_b1 takes data, q_b2 takes the old q_b1, q_b3 takes the old q_b2.
REQ-021 With BLOCKING_PIPE_CMP_EN defined, q_b outputs and mismatch SHALL reset to 0 asynchronously on rstn=0.
REQ-022 With BLOCKING_PIPE_CMP_EN defined, mismatch SHALL be a registered flag set to 1 when the next-state q_a3_reg differs from the next-state q_b3_reg, else 0.
REQ-023 Without BLOCKING_PIPE_CMP_EN, these ports SHALL be absent and behaviour SHALL be per REQ-009..REQ-018 only.

Verification
REQ-024 Reset: rstn=0 with data=0xFD and clk running -> all outputs 0x00.
REQ-025 Load: rstn=1, data=0xFD before an edge -> after that edge all three q_a outputs = 0xFD.
REQ-026 Sequence: data 0x01, then 0xEE, then 0x82, then 0x77, then 0xD4, each held over one edge -> all three q_a outputs show each value one edge later and are always equal.
REQ-027 Mid-cycle change: data 0x82 changed to 0x77 between edges -> outputs skip 0x82 and only show the value present at the edge.
REQ-028 Async reset: rstn pulled low between edges while outputs = 0xD4 -> outputs 0x00 immediately, with no clk edge required.
REQ-029 With BLOCKING_PIPE_CMP_EN defined: data 0x01, 0x02, 0x03 on successive edges -> q_b3_reg = 0x01 after the third edge while q_a3_reg = 0x03, and mismatch = 1.

Source files
------------

// File: rtl/blocking.sv
// Three-stage "collapsing" register chain: every edge loads data into all three stages.
// Latency: 1 clk edge from data to every output; optional compare chain adds a shift pipe.
// Backpressure: none -- every rising edge loads, there is no enable or handshake.
//
// Optional feature macro: BLOCKING_PIPE_CMP_EN adds a true 3-stage shift chain
// (q_b1_reg..q_b3_reg) and a registered mismatch flag comparing q_a3 against q_b3.
module blocking #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [WIDTH-1:0] data,
    output logic [WIDTH-1:0] q_a1_reg,
    output logic [WIDTH-1:0] q_a2_reg,
`ifdef BLOCKING_PIPE_CMP_EN
    output logic [WIDTH-1:0] q_a3_reg,
    output logic [WIDTH-1:0] q_b1_reg,
    output logic [WIDTH-1:0] q_b2_reg,
    output logic [WIDTH-1:0] q_b3_reg,
    output logic             mismatch
`else
    output logic [WIDTH-1:0] q_a3_reg
`endif
);

    logic [WIDTH-1:0] q_a1_q, q_a2_q, q_a3_q;
    logic [WIDTH-1:0] q_a1_d, q_a2_d, q_a3_d;

    // Ordered update: each stage takes the freshly computed value of the stage before it,
    // so all three collapse onto the sampled data in a single edge.
    always_comb begin
        q_a1_d = data;
        q_a2_d = q_a1_d;
        q_a3_d = q_a2_d;
    end

    // Stage-A registers, cleared asynchronously while rstn is low.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            q_a1_q <= '0;
            q_a2_q <= '0;
            q_a3_q <= '0;
        end else begin
            q_a1_q <= q_a1_d;
            q_a2_q <= q_a2_d;
            q_a3_q <= q_a3_d;
        end
    end

    assign q_a1_reg = q_a1_q;
    assign q_a2_reg = q_a2_q;
    assign q_a3_reg = q_a3_q;

`ifdef BLOCKING_PIPE_CMP_EN
    logic [WIDTH-1:0] q_b1_q, q_b2_q, q_b3_q;
    logic [WIDTH-1:0] q_b1_d, q_b2_d, q_b3_d;
    logic             mismatch_q, mismatch_d;

    // True shift: each stage takes the old value of its predecessor; the flag compares
    // the next-state tails so it lines up with the registered chain outputs.
    always_comb begin
        q_b1_d     = data;
        q_b2_d     = q_b1_q;
        q_b3_d     = q_b2_q;
        mismatch_d = (q_a3_d != q_b3_d);
    end

    // Stage-B shift registers and mismatch flag, cleared asynchronously.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            q_b1_q     <= '0;
            q_b2_q     <= '0;
            q_b3_q     <= '0;
            mismatch_q <= 1'b0;
        end else begin
            q_b1_q     <= q_b1_d;
            q_b2_q     <= q_b2_d;
            q_b3_q     <= q_b3_d;
            mismatch_q <= mismatch_d;
        end
    end

    assign q_b1_reg = q_b1_q;
    assign q_b2_reg = q_b2_q;
    assign q_b3_reg = q_b3_q;
    assign mismatch = mismatch_q;
`endif

endmodule

// File: tb/tb_blocking.sv
// Self-checking bench for blocking: directed vectors plus randomized data against a
// reference model ("outputs show the value present at the last edge since reset").
// Inputs change on the falling edge; outputs are sampled 1 time unit after the rising edge.
module tb_blocking;

    localparam int W = 8;

    logic         clk;
    logic         rstn;
    logic [W-1:0] data;
    logic [W-1:0] q_a1_reg, q_a2_reg, q_a3_reg;
`ifdef BLOCKING_PIPE_CMP_EN
    logic [W-1:0] q_b1_reg, q_b2_reg, q_b3_reg;
    logic         mismatch;
`endif

    int checks = 0;
    int errors = 0;

    // Reference model state: value sampled at last edge, plus history of sampled values.
    logic [W-1:0] exp_a;
    logic [W-1:0] hist [$];

    blocking #(.WIDTH(W)) dut (
        .clk      (clk),
        .rstn     (rstn),
        .data     (data),
        .q_a1_reg (q_a1_reg),
        .q_a2_reg (q_a2_reg),
`ifdef BLOCKING_PIPE_CMP_EN
        .q_a3_reg (q_a3_reg),
        .q_b1_reg (q_b1_reg),
        .q_b2_reg (q_b2_reg),
        .q_b3_reg (q_b3_reg),
        .mismatch (mismatch)
`else
        .q_a3_reg (q_a3_reg)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Clear the model, as reset does to the design.
    function automatic void model_reset();
        exp_a = '0;
        hist.delete();
        for (int i = 0; i < 3; i++) hist.push_back('0);
    endfunction

    // Drive v before the next rising edge, let the edge happen, update the model.
    task automatic step(input logic [W-1:0] v);
        @(negedge clk);
        data = v;
        @(posedge clk);
        exp_a = v;
        hist.push_front(v);
        void'(hist.pop_back());
        #1;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        data = 8'hFD;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if ({q_a1_reg, q_a2_reg, q_a3_reg} !== {3{8'h00}}) begin
                errors++;
                $display("FAIL reset_hold: got %h/%h/%h, want 00/00/00", q_a1_reg, q_a2_reg, q_a3_reg);
            end
        end
    endtask

    task automatic test_load();
        @(negedge clk);
        rstn = 1'b1;
        step(8'hFD);
        checks++;
        if ({q_a1_reg, q_a2_reg, q_a3_reg} !== {3{8'hFD}}) begin
            errors++;
            $display("FAIL first_load: got %h/%h/%h, want fd", q_a1_reg, q_a2_reg, q_a3_reg);
        end
    endtask

    task automatic test_sequence();
        logic [W-1:0] vec [5];
        vec = '{8'h01, 8'hEE, 8'h82, 8'h77, 8'hD4};
        for (int i = 0; i < 5; i++) begin
            step(vec[i]);
            checks++;
            if (q_a1_reg !== vec[i] || q_a2_reg !== vec[i] || q_a3_reg !== vec[i]) begin
                errors++;
                $display("FAIL sequence[%0d]: got %h/%h/%h, want %h", i, q_a1_reg, q_a2_reg, q_a3_reg, vec[i]);
            end
        end
    endtask

    task automatic test_midcycle();
        @(negedge clk);
        data = 8'h82;
        #2;
        checks++;
        if ({q_a1_reg, q_a2_reg, q_a3_reg} !== {3{exp_a}}) begin
            errors++;
            $display("FAIL midcycle_hold: got %h/%h/%h, want %h", q_a1_reg, q_a2_reg, q_a3_reg, exp_a);
        end
        data = 8'h77;
        @(posedge clk);
        exp_a = 8'h77;
        hist.push_front(8'h77);
        void'(hist.pop_back());
        #1;
        checks++;
        if ({q_a1_reg, q_a2_reg, q_a3_reg} !== {3{8'h77}}) begin
            errors++;
            $display("FAIL midcycle_edge: got %h/%h/%h, want 77", q_a1_reg, q_a2_reg, q_a3_reg);
        end
    endtask

    task automatic test_async_reset();
        step(8'hD4);
        checks++;
        if ({q_a1_reg, q_a2_reg, q_a3_reg} !== {3{8'hD4}}) begin
            errors++;
            $display("FAIL pre_reset_value: got %h/%h/%h, want d4", q_a1_reg, q_a2_reg, q_a3_reg);
        end
        @(negedge clk);
        #1;
        rstn = 1'b0;
        model_reset();
        #1;
        checks++;
        if ({q_a1_reg, q_a2_reg, q_a3_reg} !== {3{8'h00}}) begin
            errors++;
            $display("FAIL async_clear: got %h/%h/%h, want 00", q_a1_reg, q_a2_reg, q_a3_reg);
        end
        @(negedge clk);
        rstn = 1'b1;
        step(8'h5A);
        checks++;
        if ({q_a1_reg, q_a2_reg, q_a3_reg} !== {3{8'h5A}}) begin
            errors++;
            $display("FAIL post_reset_load: got %h/%h/%h, want 5a", q_a1_reg, q_a2_reg, q_a3_reg);
        end
    endtask

    task automatic test_random();
        logic [W-1:0] v;
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 19) == 0) begin
                @(negedge clk);
                #2;
                rstn = 1'b0;
                model_reset();
                #1;
                rstn = 1'b1;
            end
            v = W'($urandom);
            step(v);
            checks++;
            if (q_a1_reg !== exp_a || q_a2_reg !== exp_a || q_a3_reg !== exp_a) begin
                errors++;
                $display("FAIL random[%0d]: got %h/%h/%h, want %h", i, q_a1_reg, q_a2_reg, q_a3_reg, exp_a);
            end
`ifdef BLOCKING_PIPE_CMP_EN
            checks++;
            if ({q_b1_reg, q_b2_reg, q_b3_reg} !== {hist[0], hist[1], hist[2]} ||
                mismatch !== (exp_a != hist[2])) begin
                errors++;
                $display("FAIL random_bchain[%0d]: got %h/%h/%h mm=%b, want %h/%h/%h mm=%b", i,
                         q_b1_reg, q_b2_reg, q_b3_reg, mismatch, hist[0], hist[1], hist[2], exp_a != hist[2]);
            end
`endif
        end
    endtask

`ifdef BLOCKING_PIPE_CMP_EN
    task automatic test_cmp();
        @(negedge clk);
        rstn = 1'b0;
        model_reset();
        @(negedge clk);
        rstn = 1'b1;
        step(8'h01);
        step(8'h02);
        step(8'h03);
        checks++;
        if (q_b3_reg !== 8'h01 || q_a3_reg !== 8'h03 || mismatch !== 1'b1) begin
            errors++;
            $display("FAIL cmp_shift: got b3=%h a3=%h mm=%b, want b3=01 a3=03 mm=1", q_b3_reg, q_a3_reg, mismatch);
        end
        step(8'h03);
        step(8'h03);
        checks++;
        if (q_b3_reg !== 8'h03 || mismatch !== 1'b0) begin
            errors++;
            $display("FAIL cmp_equal: got b3=%h mm=%b, want b3=03 mm=0", q_b3_reg, mismatch);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_load();
        test_sequence();
        test_midcycle();
        test_async_reset();
        test_random();
`ifdef BLOCKING_PIPE_CMP_EN
        test_cmp();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
